phy_loopback_checker: RTL

Synthesizable, parametrised successor to the single-word PHY data assertion check. Captures transmitted words into an expected-data FIFO and compares them in order against received words arriving after an unknown, variable latency. Tracks lock, counts matches and errors, and flags timeout and overflow. Sits beside the PHY in the verification/BIST path; it is also usable on silicon.

---
 rtl/phy_loopback_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/phy_loopback_checker.sv
// phy_loopback_checker: captures transmitted words into an expected-data FIFO
// and compares them in order against received words arriving after an unknown
// latency. Tracks lock, counts matches/errors, flags timeout and overflow.
// Optional compile-time feature: define PHY_CHK_MASK_EN to add a cmp_mask
// input; only bits set in cmp_mask take part in the compare.
module phy_loopback_checker #(
    parameter int DATA_BUS_WIDTH = 32,
    parameter int DEPTH          = 16,
    parameter int MAX_LATENCY    = 64,
    parameter int LOCK_LOSS      = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [DATA_BUS_WIDTH-1:0]  Data_in,
    input  logic                       out_valid,
    input  logic [DATA_BUS_WIDTH-1:0]  Data_out,
`ifdef PHY_CHK_MASK_EN
    input  logic [DATA_BUS_WIDTH-1:0]  cmp_mask,
`endif
    output logic                       locked,
    output logic                       err_pulse,
    output logic [CNT_WIDTH-1:0]       match_cnt,
    output logic [CNT_WIDTH-1:0]       err_cnt,
    output logic                       timeout,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int RW = $clog2(LOCK_LOSS + 1);
    localparam int TW = $clog2(MAX_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

    state_t                    state, state_nxt;
    logic [DATA_BUS_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [LW-1:0]             level;
    logic [RW-1:0]             run, run_nxt;
    logic [TW-1:0]             lat, lat_nxt;
    logic [DATA_BUS_WIDTH-1:0] mask;
    logic                      empty, full, cmp, hit, pop, push;
    logic                      ovf_set, to_fire, err_ev, match_ev;

    assign locked     = (state == LOCKED);
    assign fifo_level = level;

    // Compare/pop/push decisions and next-state logic.
    always_comb begin
        mask      = '1;
`ifdef PHY_CHK_MASK_EN
        mask      = cmp_mask;
`endif
        empty     = (level == '0);
        full      = (level == LW'(DEPTH));
        // The head is only comparable once it is stored, so a word pushed
        // this cycle never participates: level is the registered count.
        cmp       = out_valid && !empty && (state != IDLE);
        hit       = ((mem[rd_ptr] ^ Data_out) & mask) == '0;
        // SEARCH holds the head on a mismatch to keep hunting for alignment.
        pop       = cmp && ((state == LOCKED) || hit);
        // A pop frees a slot in the same cycle, so push-at-full with pop is legal.
        push      = enable && (!full || pop);
        ovf_set   = enable && full && !pop;
        // A pop clears the latency watch, so it wins over an expiring timer.
        to_fire   = !empty && !pop && (lat == TW'(MAX_LATENCY - 1));
        lat_nxt   = (empty || pop || to_fire) ? '0 : lat + 1'b1;
        match_ev  = cmp && hit;
        err_ev    = 1'b0;
        run_nxt   = run;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (push) state_nxt = SEARCH;
            end
            SEARCH: begin
                if (match_ev) begin
                    state_nxt = LOCKED;
                    run_nxt   = '0;
                end
            end
            LOCKED: begin
                if (out_valid && empty) begin
                    err_ev = 1'b1;              // unexpected word
                end else if (cmp) begin
                    if (hit) begin
                        run_nxt = '0;
                    end else begin
                        err_ev = 1'b1;
                        if (run == RW'(LOCK_LOSS - 1)) begin
                            run_nxt   = '0;
                            state_nxt = SEARCH;
                        end else begin
                            run_nxt = run + 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (to_fire) begin
            state_nxt = IDLE;
            run_nxt   = '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FIFO pointers, level, run/latency trackers, counters and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            run       <= '0;
            lat       <= '0;
            err_pulse <= 1'b0;
            match_cnt <= '0;
            err_cnt   <= '0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            run       <= run_nxt;
            lat       <= lat_nxt;
            err_pulse <= err_ev;
            if (match_ev && (match_cnt != '1)) match_cnt <= match_cnt + 1'b1;
            if (err_ev && (err_cnt != '1))     err_cnt   <= err_cnt + 1'b1;
            if (ovf_set) overflow <= 1'b1;
            if (to_fire) begin
                timeout <= 1'b1;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level   <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end

    // Expected-data storage; contents need no reset since level gates use.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= Data_in;
    end
endmodule
